hilo_muldiv: RTL and testbench
==============================

Name: hilo_muldiv

Overview:
- Multi-cycle multiply/divide unit: the producer (write side) of the HI/LO register pair.
- Sits in EX: accepts MULT/MULTU/DIV/DIVU operands, stalls the pipeline while iterating, then issues a one-cycle write of the 64-bit {HI,LO} result.
- The HI/LO register captures `hilo_data` on the rising edge where `hilo_we`=1.

Parameters:
- XLEN, 32, operand width; result width is 2*XLEN; iteration count is XLEN.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only in IDLE
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  input  XLEN  multiplicand / dividend
- src_b  input  XLEN  multiplier / divisor
- cancel  input  1  pipeline flush (exception); aborts the current operation
- stall  output  1  hold the pipeline front; combinational
- hilo_we  output  1  write strobe to HI/LO, exactly one cycle per completed op
- hilo_data  output  2*XLEN  [2X-1:X]=HI, [X-1:0]=LO

Behaviour:
- Reset (asynchronous, active-high; also mid-operation):
  - state=IDLE, counter=0, internal registers=0.
  - hilo_we=0, hilo_data=0, stall=0.
  - Any in-flight operation is discarded with no write.
- States: IDLE, CALC, DONE.
- IDLE:
  - On start=1 and cancel=0: latch op and |src_a|, |src_b| (absolute values for signed ops), latch the result sign flags, counter=0.
  - Divisor==0 on DIV/DIVU: go to DONE; otherwise go to CALC.
- CALC:
  - One radix-2 step per cycle; counter increments.
  - After step XLEN-1, go to DONE. Normal latency is start cycle T -> DONE at T+XLEN+1 (T+33 for XLEN=32).
- DONE:
  - hilo_we=1 for exactly one cycle; hilo_data holds the sign-corrected result; then return to IDLE.
  - hilo_data holds its last value in all other states; it is only meaningful while hilo_we=1.
- Multiply: shift-add on unsigned magnitudes. HI:LO = full 2*XLEN-bit product, negated if the operand signs differ (MULT only).
- Divide: restoring division.
  - LO = quotient, negated if signs differ (DIV only).
  - HI = remainder, carrying the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0 (wraps, no trap).
- Divide by zero: HI=src_a, LO=all ones. Reaches DONE one cycle after start, signed or unsigned.
- stall = (state==IDLE & start & ~cancel) | (state==CALC).
  - stall is low in DONE so the instruction advances while the write lands.
- start while in CALC or DONE: ignored; no queueing.
- cancel in CALC or DONE: next state IDLE. hilo_we is forced 0 in that same cycle, so no write occurs.
- cancel together with start in IDLE: start is not accepted.

Optional Feature:
- Macro: HILO_FAST_MULT_EN.
- Defined: MULT/MULTU use a single combinational XLEN x XLEN multiply registered at accept. They skip CALC and go IDLE->DONE, so hilo_we asserts at T+1. Division is unchanged.
- Undefined: all ops iterate as described above (multiply latency T+XLEN+1).

Decomposition:
- Package muldiv_pkg holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - state enum: IDLE, CALC, DONE;
  - XLEN default and the counter width $clog2(XLEN).
- One natural sub-module, hilo_div_step: combinational single restoring-division step (partial remainder, divisor) -> (next remainder, quotient bit). It is instantiated once and reused every CALC cycle.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> stall high for 33 cycles (T..T+32); at T+33 hilo_we=1, hilo_data=0xFFFFFFFE_00000001.
- MULT 0xFFFFFFFE(-2) x 3 -> hilo_data=0xFFFFFFFF_FFFFFFFA. With HILO_FAST_MULT_EN, hilo_we=1 at T+1.
- DIV 0xFFFFFFF9(-7) / 2 -> LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1). DIVU 100 / 7 -> LO=14, HI=2.
- DIVU 5 / 0 -> hilo_we at T+1, hilo_data=0x00000005_FFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- cancel at cycle T+10 of a DIV -> returns to IDLE, hilo_we never asserts. Also: rst asserted mid-CALC asynchronously clears stall and hilo_data=0; start pulsed during CALC is ignored.
- Back-to-back start held high -> second op accepted on the cycle after DONE, and exactly one hilo_we pulse per op.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings and sizing for the HI/LO multiply/divide unit.
// Operation codes, FSM states, default operand width and counter width.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;
  localparam int CNT_W    = $clog2(XLEN_DEF);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/hilo_div_step.sv
// hilo_div_step: one combinational restoring-division step.
// Shifted partial remainder vs divisor -> next remainder and quotient bit.
module hilo_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   part,
  input  logic [XLEN-1:0] dvsr,
  output logic [XLEN-1:0] rem,
  output logic            q_bit
);

  logic [XLEN:0] diff;

  // part < 2*dvsr always holds, so a clear borrow bit means part >= dvsr
  assign diff  = part - {1'b0, dvsr};
  assign q_bit = ~diff[XLEN];
  assign rem   = q_bit ? diff[XLEN-1:0] : part[XLEN-1:0];

endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: multi-cycle MULT/MULTU/DIV/DIVU unit driving the HI/LO write port.
// Define HILO_FAST_MULT_EN to perform multiplies in a single cycle.
module hilo_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [XLEN-1:0]   src_a,
  input  logic [XLEN-1:0]   src_b,
  input  logic              cancel,
  output logic              stall,
  output logic              hilo_we,
  output logic [2*XLEN-1:0] hilo_data
);

  localparam int CW = (XLEN == XLEN_DEF) ? CNT_W : $clog2(XLEN);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   hi_q, lo_q, b_q;
  logic              is_div_q, neg_lo_q, neg_hi_q;
  logic [2*XLEN-1:0] hilo_q;

  op_e             op_in;
  logic            is_div_in, is_sgn_in;
  logic            a_neg, b_neg, b_zero;
  logic            accept, fast_in, last;
  logic [XLEN-1:0] a_mag, b_mag;

  assign op_in     = op_e'(op);
  assign is_div_in = (op_in == OP_DIV) || (op_in == OP_DIVU);
  assign is_sgn_in = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign a_neg     = is_sgn_in & src_a[XLEN-1];
  assign b_neg     = is_sgn_in & src_b[XLEN-1];
  assign a_mag     = a_neg ? -src_a : src_a;
  assign b_mag     = b_neg ? -src_b : src_b;
  assign b_zero    = (src_b == '0);
  assign accept    = (state_q == IDLE) & start & ~cancel;
  assign last      = (cnt_q == CW'(XLEN - 1));

`ifdef HILO_FAST_MULT_EN
  logic [2*XLEN-1:0] prod_w;

  assign prod_w  = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
  assign fast_in = ~is_div_in;
`else
  assign fast_in = 1'b0;
`endif

  // Shared HI/LO datapath: lo_q shifts out multiplier/dividend bits.
  logic [XLEN:0]   sum_w;
  logic [XLEN-1:0] step_rem;
  logic            step_q;
  logic [XLEN-1:0] hi_n, lo_n;

  assign sum_w = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : '0)};

  hilo_div_step #(
    .XLEN(XLEN)
  ) u_step (
    .part  ({hi_q, lo_q[XLEN-1]}),
    .dvsr  (b_q),
    .rem   (step_rem),
    .q_bit (step_q)
  );

  always_comb begin
    hi_n = sum_w[XLEN:1];
    lo_n = {sum_w[0], lo_q[XLEN-1:1]};
    if (is_div_q) begin
      hi_n = step_rem;
      lo_n = {lo_q[XLEN-2:0], step_q};
    end
  end

  function automatic logic [2*XLEN-1:0] fix(
    input logic            div,
    input logic            neg_lo,
    input logic            neg_hi,
    input logic [XLEN-1:0] h,
    input logic [XLEN-1:0] l
  );
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   fh, fl;
    p  = {h, l};
    fh = neg_hi ? -h : h;
    fl = neg_lo ? -l : l;
    if (!div) return neg_lo ? -p : p;
    return {fh, fl};
  endfunction

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if ((is_div_in && b_zero) || fast_in) state_d = DONE;
          else                                  state_d = CALC;
        end
      end
      CALC: begin
        if (cancel)    state_d = IDLE;
        else if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hilo_q   <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            hi_q     <= '0;
            lo_q     <= a_mag;
            b_q      <= b_mag;
            cnt_q    <= '0;
            is_div_q <= is_div_in;
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= a_neg & is_div_in;
            if (is_div_in && b_zero)
              hilo_q <= {src_a, {XLEN{1'b1}}};
`ifdef HILO_FAST_MULT_EN
            else if (fast_in)
              hilo_q <= fix(1'b0, a_neg ^ b_neg, 1'b0,
                            prod_w[2*XLEN-1:XLEN],
                            prod_w[XLEN-1:0]);
`endif
          end
        end
        CALC: begin
          if (!cancel) begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q + 1'b1;
            if (last)
              hilo_q <= fix(is_div_q, neg_lo_q, neg_hi_q,
                            hi_n, lo_n);
          end
        end
        default: ;
      endcase
    end
  end

  assign stall     = accept | (state_q == CALC);
  assign hilo_we   = (state_q == DONE) & ~cancel;
  assign hilo_data = hilo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: directed self-checking bench for the HI/LO multiply/divide unit.
// Hand-computed vectors: latency, stall length, results, cancel, reset, back-to-back.
module tb_hilo_muldiv;

  localparam int X = 32;
  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;
`ifdef HILO_FAST_MULT_EN
  localparam int ML = 1;
`else
  localparam int ML = 33;
`endif

  logic         clk = 1'b0;
  logic         rst, start, cancel;
  logic [1:0]   op;
  logic [X-1:0] src_a, src_b;
  logic         stall, hilo_we;
  logic [2*X-1:0] hilo_data;

  int n_chk = 0;
  int n_fail = 0;

  hilo_muldiv #(
    .XLEN(X)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .cancel    (cancel),
    .stall     (stall),
    .hilo_we   (hilo_we),
    .hilo_data (hilo_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int lat,
                        input int poke);
    int n;
    int st;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    #1;
    st = stall ? 1 : 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 1;
    @(negedge clk);
    while (!hilo_we && n < 100) begin
      if (stall) st++;
      start = (n == poke);
      if (n == poke) begin
        op    = MULTU;
        src_a = 32'hFFFF_FFFF;
        src_b = 32'hFFFF_FFFF;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_stl"}, 64'(st), 64'(lat));
    chk({tag, "_dat"}, hilo_data, exp);
    chk({tag, "_dstl"}, 64'(stall), 64'd0);
    @(negedge clk);
    chk({tag, "_one"}, 64'(hilo_we), 64'd0);
  endtask

  initial begin
    int we_cnt;
    int t1;
    int t2;
    rst    = 1'b1;
    start  = 1'b0;
    cancel = 1'b0;
    op     = 2'b00;
    src_a  = '0;
    src_b  = '0;
    #12;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_we", 64'(hilo_we), 64'd0);
    chk("rst_data", hilo_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           64'hFFFF_FFFE_0000_0001, ML, 0);
    run_op("mult_n2x3", MULT, 32'hFFFF_FFFE, 32'd3,
           64'hFFFF_FFFF_FFFF_FFFA, ML, 0);
    run_op("mult_7xn5", MULT, 32'd7, 32'hFFFF_FFFB,
           64'hFFFF_FFFF_FFFF_FFDD, ML, 0);
    run_op("mult_min2", MULT, 32'h8000_0000, 32'h8000_0000,
           64'h4000_0000_0000_0000, ML, 0);
    run_op("div_n7d2", DIV, 32'hFFFF_FFF9, 32'd2,
           64'hFFFF_FFFF_FFFF_FFFD, 33, 0);
    run_op("div_7dn2", DIV, 32'd7, 32'hFFFF_FFFE,
           64'h0000_0001_FFFF_FFFD, 33, 0);
    run_op("divu_100_7", DIVU, 32'd100, 32'd7,
           64'h0000_0002_0000_000E, 33, 0);
    run_op("divu_max_1", DIVU, 32'hFFFF_FFFF, 32'd1,
           64'h0000_0000_FFFF_FFFF, 33, 0);
    run_op("divu_5_0", DIVU, 32'd5, 32'd0,
           64'h0000_0005_FFFF_FFFF, 1, 0);
    run_op("div_n5_0", DIV, 32'hFFFF_FFFB, 32'd0,
           64'hFFFF_FFFB_FFFF_FFFF, 1, 0);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           64'h0000_0000_8000_0000, 33, 0);
    run_op("div_poke", DIVU, 32'd100, 32'd7,
           64'h0000_0002_0000_000E, 33, 5);

    // cancel at T+10 of a divide
    @(negedge clk);
    start = 1'b1;
    op    = DIV;
    src_a = 32'd1000;
    src_b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("cnc_busy", 64'(stall), 64'd1);
    cancel = 1'b1;
    #1;
    chk("cnc_we", 64'(hilo_we), 64'd0);
    @(negedge clk);
    cancel = 1'b0;
    chk("cnc_idle", 64'(stall), 64'd0);
    we_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (hilo_we) we_cnt++;
    end
    chk("cnc_nowe", 64'(we_cnt), 64'd0);

    // asynchronous reset mid-CALC
    @(negedge clk);
    start = 1'b1;
    op    = DIVU;
    src_a = 32'd100;
    src_b = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_stall", 64'(stall), 64'd0);
    chk("arst_data", hilo_data, 64'd0);
    chk("arst_we", 64'(hilo_we), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    we_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (hilo_we) we_cnt++;
    end
    chk("arst_nowe", 64'(we_cnt), 64'd0);
    run_op("arst_after", DIVU, 32'd100, 32'd7,
           64'h0000_0002_0000_000E, 33, 0);

    // start held high: two ops, one pulse each
    @(negedge clk);
    start = 1'b1;
    op    = DIVU;
    src_a = 32'd100;
    src_b = 32'd7;
    we_cnt = 0;
    t1 = 0;
    t2 = 0;
    for (int i = 1; i <= 110; i++) begin
      @(negedge clk);
      if (hilo_we) begin
        we_cnt++;
        if (t1 == 0) t1 = i;
        else t2 = i;
        chk("b2b_dat", hilo_data, 64'h0000_0002_0000_000E);
        chk("b2b_stl", 64'(stall), 64'd0);
      end
      if (i == 67) start = 1'b0;
    end
    chk("b2b_cnt", 64'(we_cnt), 64'd2);
    chk("b2b_t1", 64'(t1), 64'd33);
    chk("b2b_t2", 64'(t2), 64'd67);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
